// File: rtl/remote_load_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : remote_load_wb_pkg
// Description : Shared types for the remote load writeback path. It holds the
//               load info returned with every remote response, the queue entry
//               type, the writeback route and the queue state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package remote_load_wb_pkg;

    localparam int RV32_reg_addr_width_gp = 5;
    localparam int RL_DATA_WIDTH          = 32;

    // Load info sent with a request and echoed back with its response.
    typedef struct packed {
        logic       float_wb;
        logic       icache_fetch;
        logic       is_unsigned_op;
        logic       is_byte_op;
        logic       is_hex_op;
        logic [1:0] part_sel;
    } bsg_manycore_load_info_s;

    // One buffered network response; this is the writeback queue entry.
    typedef struct packed {
        logic [RL_DATA_WIDTH-1:0]          data;
        bsg_manycore_load_info_s           load_info;
        logic [RV32_reg_addr_width_gp-1:0] reg_id;
    } remote_load_resp_s;

    typedef enum logic [1:0] {
        ROUTE_INT    = 2'd0,
        ROUTE_FLOAT  = 2'd1,
        ROUTE_ICACHE = 2'd2
    } remote_load_route_e;

    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } rlwb_queue_state_e;

endpackage
`default_nettype wire

// File: rtl/remote_load_extract.sv
`default_nettype none
// ============================================================================
// Module      : remote_load_extract
// Description : Combinational decode of one remote load response. It selects
//               the destination (int / float / icache), pulls the byte or
//               halfword out of the returned word and sign/zero extends it.
//               It also reports an integer load aimed at x0, which the
//               consumer discards.
// Ports       : i_entry   - response entry (data, load info, reg id)
//               o_data    - extracted and extended result
//               o_route   - destination port
//               o_discard - integer load to x0, nothing to write back
// Revision    : 1.0 - initial release
// ============================================================================
module remote_load_extract
    import remote_load_wb_pkg::*;
(
    input  remote_load_resp_s        i_entry,
    output logic [RL_DATA_WIDTH-1:0] o_data,
    output remote_load_route_e       o_route,
    output logic                     o_discard
);

    logic [RL_DATA_WIDTH-1:0] w_byte_shift;
    logic [RL_DATA_WIDTH-1:0] w_hex_shift;
    logic [7:0]               w_byte;
    logic [15:0]              w_hex;
    logic                     w_sext;

    // Shift amounts are part_sel*8 and part_sel[1]*16, built by concatenation.
    assign w_byte_shift = i_entry.data >> {i_entry.load_info.part_sel, 3'b000};
    assign w_hex_shift  = i_entry.data >> {i_entry.load_info.part_sel[1], 4'b0000};
    assign w_byte       = w_byte_shift[7:0];
    assign w_hex        = w_hex_shift[15:0];
    assign w_sext       = ~i_entry.load_info.is_unsigned_op;

    always_comb begin
        o_data    = i_entry.data;
        o_route   = ROUTE_INT;
        o_discard = 1'b0;
        // icache fetch has priority over float; both carry the raw word.
        if (i_entry.load_info.icache_fetch) begin
            o_route = ROUTE_ICACHE;
        end else if (i_entry.load_info.float_wb) begin
            o_route = ROUTE_FLOAT;
        end else begin
            o_route   = ROUTE_INT;
            o_discard = (i_entry.reg_id == '0);
            if (i_entry.load_info.is_byte_op) begin
                o_data = {{24{w_sext & w_byte[7]}}, w_byte};
            end else if (i_entry.load_info.is_hex_op) begin
                o_data = {{16{w_sext & w_hex[15]}}, w_hex};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/remote_load_wb.sv
`default_nettype none
// ============================================================================
// Module      : remote_load_wb
// Description : Writeback unit for remote load / icache-fetch responses. Buffers
//               responses in a two-entry queue, extracts and extends the loaded
//               value, routes the head entry to the int, float or icache port
//               and tracks the number of outstanding remote loads.
// Ports       : clk_i, reset_i (async, active-low)
//               issue_i                        - remote request issued
//               resp_v_i/resp_*_i/resp_ready_o - network response in
//               int_wb_*, float_wb_*           - register file writebacks
//               icache_*                       - icache refill word
//               out_count_o/out_full_o/idle_o  - outstanding load tracking
// Config      : REMOTE_LOAD_WB_BYPASS_EN - when defined, a response arriving at
//               an empty queue is presented in the same cycle and, if taken,
//               never enters the queue. Undefined: registered one-cycle path.
// Revision    : 1.0 - initial release
// ============================================================================
module remote_load_wb
    import remote_load_wb_pkg::*;
#(
    parameter int data_width_p      = 32,
    parameter int reg_addr_width_lp = RV32_reg_addr_width_gp,
    parameter int max_out_p         = 16,
    parameter int out_width_lp      = $clog2(max_out_p + 1)
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,
    input  logic                                        issue_i,
    input  logic                                        resp_v_i,
    input  logic [data_width_p-1:0]                     resp_data_i,
    input  logic [$bits(bsg_manycore_load_info_s)-1:0]  resp_load_info_i,
    input  logic [reg_addr_width_lp-1:0]                resp_reg_id_i,
    output logic                                        resp_ready_o,
    output logic                                        int_wb_v_o,
    output logic [reg_addr_width_lp-1:0]                int_wb_rd_o,
    output logic [data_width_p-1:0]                     int_wb_data_o,
    input  logic                                        int_wb_yumi_i,
    output logic                                        float_wb_v_o,
    output logic [reg_addr_width_lp-1:0]                float_wb_rd_o,
    output logic [data_width_p-1:0]                     float_wb_data_o,
    input  logic                                        float_wb_yumi_i,
    output logic                                        icache_v_o,
    output logic [data_width_p-1:0]                     icache_data_o,
    input  logic                                        icache_yumi_i,
    output logic [out_width_lp-1:0]                     out_count_o,
    output logic                                        out_full_o,
    output logic                                        idle_o
);

    localparam logic [out_width_lp-1:0] c_out_max = out_width_lp'(max_out_p);

    rlwb_queue_state_e        r_state;
    rlwb_queue_state_e        w_state_next;
    remote_load_resp_s        r_q0;      // head entry
    remote_load_resp_s        r_q1;      // second entry
    remote_load_resp_s        w_in;
    remote_load_resp_s        w_head;
    logic                     w_head_v;
    logic [RL_DATA_WIDTH-1:0] w_ext_data;
    remote_load_route_e       w_route;
    logic                     w_discard;
    logic                     w_drop;
    logic                     w_deq;
    logic                     w_q_deq;
    logic                     w_enq;
    logic                     w_load_q0;
    logic                     w_q0_from_q1;
    logic                     w_load_q1;
    logic [out_width_lp-1:0]  r_count;

    always_comb begin
        w_in           = '0;
        w_in.data      = resp_data_i;
        w_in.load_info = bsg_manycore_load_info_s'(resp_load_info_i);
        w_in.reg_id    = resp_reg_id_i;
    end

    // ------------------------------------------------------------------
    // Head selection
    // ------------------------------------------------------------------
`ifdef REMOTE_LOAD_WB_BYPASS_EN
    logic w_bypass;
    assign w_bypass = (r_state == Q_EMPTY) & resp_v_i;
    assign w_head   = w_bypass ? w_in : r_q0;
    assign w_head_v = (r_state != Q_EMPTY) | resp_v_i;
`else
    assign w_head   = r_q0;
    assign w_head_v = (r_state != Q_EMPTY);
`endif

    remote_load_extract u_extract (
        .i_entry   (w_head),
        .o_data    (w_ext_data),
        .o_route   (w_route),
        .o_discard (w_discard)
    );

    // x0 writebacks are consumed silently the cycle they reach the head.
    assign w_drop       = w_head_v & w_discard;
    assign int_wb_v_o   = w_head_v & (w_route == ROUTE_INT) & ~w_discard;
    assign float_wb_v_o = w_head_v & (w_route == ROUTE_FLOAT);
    assign icache_v_o   = w_head_v & (w_route == ROUTE_ICACHE);

    assign int_wb_rd_o     = int_wb_v_o   ? w_head.reg_id : '0;
    assign int_wb_data_o   = int_wb_v_o   ? w_ext_data    : '0;
    assign float_wb_rd_o   = float_wb_v_o ? w_head.reg_id : '0;
    assign float_wb_data_o = float_wb_v_o ? w_ext_data    : '0;
    assign icache_data_o   = icache_v_o   ? w_ext_data    : '0;

    assign w_deq = w_drop
                 | (int_wb_v_o   & int_wb_yumi_i)
                 | (float_wb_v_o & float_wb_yumi_i)
                 | (icache_v_o   & icache_yumi_i);

    // Ready is a pure function of queue state.
    assign resp_ready_o = (r_state != Q_FULL);

`ifdef REMOTE_LOAD_WB_BYPASS_EN
    // A bypassed response consumed in its arrival cycle never enters the queue.
    assign w_enq   = resp_v_i & resp_ready_o & ~(w_bypass & w_deq);
    assign w_q_deq = w_deq & (r_state != Q_EMPTY);
`else
    assign w_enq   = resp_v_i & resp_ready_o;
    assign w_q_deq = w_deq;
`endif

    // ------------------------------------------------------------------
    // Queue control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load_q0    = 1'b0;
        w_q0_from_q1 = 1'b0;
        w_load_q1    = 1'b0;
        case (r_state)
            Q_EMPTY: begin
                if (w_enq) begin
                    w_state_next = Q_ONE;
                    w_load_q0    = 1'b1;
                end
            end
            Q_ONE: begin
                if (w_enq & w_q_deq) begin
                    w_load_q0 = 1'b1;
                end else if (w_enq) begin
                    w_state_next = Q_FULL;
                    w_load_q1    = 1'b1;
                end else if (w_q_deq) begin
                    w_state_next = Q_EMPTY;
                end
            end
            Q_FULL: begin
                if (w_q_deq) begin
                    w_state_next = Q_ONE;
                    w_load_q0    = 1'b1;
                    w_q0_from_q1 = 1'b1;
                end
            end
            default: begin
                w_state_next = Q_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= Q_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_q0 <= '0;
            r_q1 <= '0;
        end else begin
            if (w_load_q0) begin
                r_q0 <= w_q0_from_q1 ? r_q1 : w_in;
            end
            if (w_load_q1) begin
                r_q1 <= w_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding load counter (saturates at both ends)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_count <= '0;
        end else if (issue_i & ~w_deq) begin
            if (r_count != c_out_max) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_deq & ~issue_i) begin
            if (r_count != '0) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign out_count_o = r_count;
    assign out_full_o  = (r_count == c_out_max);
    assign idle_o      = (r_state == Q_EMPTY) & (r_count == '0);

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if (issue_i & out_full_o)
                $error("remote_load_wb: issue while outstanding count is full");
            if (w_deq & (r_count == '0))
                $error("remote_load_wb: dequeue with zero outstanding loads");
            if (int_wb_yumi_i & ~int_wb_v_o)
                $error("remote_load_wb: int yumi without valid");
            if (float_wb_yumi_i & ~float_wb_v_o)
                $error("remote_load_wb: float yumi without valid");
            if (icache_yumi_i & ~icache_v_o)
                $error("remote_load_wb: icache yumi without valid");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_remote_load_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_remote_load_wb
// Description : Self-checking bench for remote_load_wb. Directed cases with
//               literal expectations, then randomized traffic compared every
//               cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_remote_load_wb;
    import remote_load_wb_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        issue_i;
    logic        resp_v_i;
    logic [31:0] resp_data_i;
    logic [6:0]  resp_load_info_i;
    logic [4:0]  resp_reg_id_i;
    logic        resp_ready_o;
    logic        int_wb_v_o;
    logic [4:0]  int_wb_rd_o;
    logic [31:0] int_wb_data_o;
    logic        int_wb_yumi_i;
    logic        float_wb_v_o;
    logic [4:0]  float_wb_rd_o;
    logic [31:0] float_wb_data_o;
    logic        float_wb_yumi_i;
    logic        icache_v_o;
    logic [31:0] icache_data_o;
    logic        icache_yumi_i;
    logic [4:0]  out_count_o;
    logic        out_full_o;
    logic        idle_o;

    always #5 clk_i = ~clk_i;

    remote_load_wb dut (
        .clk_i            (clk_i),
        .reset_i          (reset_i),
        .issue_i          (issue_i),
        .resp_v_i         (resp_v_i),
        .resp_data_i      (resp_data_i),
        .resp_load_info_i (resp_load_info_i),
        .resp_reg_id_i    (resp_reg_id_i),
        .resp_ready_o     (resp_ready_o),
        .int_wb_v_o       (int_wb_v_o),
        .int_wb_rd_o      (int_wb_rd_o),
        .int_wb_data_o    (int_wb_data_o),
        .int_wb_yumi_i    (int_wb_yumi_i),
        .float_wb_v_o     (float_wb_v_o),
        .float_wb_rd_o    (float_wb_rd_o),
        .float_wb_data_o  (float_wb_data_o),
        .float_wb_yumi_i  (float_wb_yumi_i),
        .icache_v_o       (icache_v_o),
        .icache_data_o    (icache_data_o),
        .icache_yumi_i    (icache_yumi_i),
        .out_count_o      (out_count_o),
        .out_full_o       (out_full_o),
        .idle_o           (idle_o)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    remote_load_resp_s mq[$];
    int                mcnt;
    int                mpend;   // issued requests whose response is not yet accepted

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bsg_manycore_load_info_s mk_info(input logic f, input logic ic, input logic uns,
                                                        input logic b, input logic h, input logic [1:0] ps);
        bsg_manycore_load_info_s li;
        li.float_wb       = f;
        li.icache_fetch   = ic;
        li.is_unsigned_op = uns;
        li.is_byte_op     = b;
        li.is_hex_op      = h;
        li.part_sel       = ps;
        return li;
    endfunction

    // 0 = int, 1 = float, 2 = icache
    function automatic int route_of(input remote_load_resp_s e);
        if (e.load_info.icache_fetch) return 2;
        if (e.load_info.float_wb)     return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_value(input remote_load_resp_s e);
        logic [31:0] v;
        if (route_of(e) != 0) return e.data;
        if (e.load_info.is_byte_op) begin
            v = (e.data >> (8 * int'(e.load_info.part_sel))) & 32'hFF;
            if (!e.load_info.is_unsigned_op && v[7]) v = v | 32'hFFFF_FF00;
            return v;
        end
        if (e.load_info.is_hex_op) begin
            v = (e.data >> (16 * int'(e.load_info.part_sel[1]))) & 32'hFFFF;
            if (!e.load_info.is_unsigned_op && v[15]) v = v | 32'hFFFF_0000;
            return v;
        end
        return e.data;
    endfunction

    function automatic remote_load_resp_s incoming();
        remote_load_resp_s e;
        e.data      = resp_data_i;
        e.load_info = bsg_manycore_load_info_s'(resp_load_info_i);
        e.reg_id    = resp_reg_id_i;
        return e;
    endfunction

    // Which entry the model presents this cycle, given the response input.
    function automatic bit head_of(input logic rv, input remote_load_resp_s inc, output remote_load_resp_s h);
        h = '0;
        if (mq.size() > 0) begin
            h = mq[0];
            return 1'b1;
        end
`ifdef REMOTE_LOAD_WB_BYPASS_EN
        if (rv) begin
            h = inc;
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic compare_model();
        remote_load_resp_s h;
        bit hv;
        int r;
        logic ev_i, ev_f, ev_c;
        hv   = head_of(resp_v_i, incoming(), h);
        r    = route_of(h);
        ev_i = hv && (r == 0) && (h.reg_id != 0);
        ev_f = hv && (r == 1);
        ev_c = hv && (r == 2);
        check("int_v",   32'(int_wb_v_o),   32'(ev_i));
        check("float_v", 32'(float_wb_v_o), 32'(ev_f));
        check("icache_v", 32'(icache_v_o),  32'(ev_c));
        if (ev_i) begin
            check("int_rd",   32'(int_wb_rd_o), 32'(h.reg_id));
            check("int_data", int_wb_data_o,    model_value(h));
        end
        if (ev_f) begin
            check("float_rd",   32'(float_wb_rd_o), 32'(h.reg_id));
            check("float_data", float_wb_data_o,    h.data);
        end
        if (ev_c) check("icache_data", icache_data_o, h.data);
        check("ready", 32'(resp_ready_o), 32'(mq.size() < 2));
        check("count", 32'(out_count_o),  32'(mcnt));
        check("full",  32'(out_full_o),   32'(mcnt == 16));
        check("idle",  32'(idle_o),       32'(mq.size() == 0 && mcnt == 0));
    endtask

    task automatic model_update();
        remote_load_resp_s h;
        remote_load_resp_s inc;
        bit hv, deq, enq, consumed_direct;
        int r;
        inc = incoming();
        hv  = head_of(resp_v_i, inc, h);
        r   = route_of(h);
        deq = hv && (((r == 0) && (h.reg_id == 0)) ||
                     ((r == 0) && int_wb_yumi_i) ||
                     ((r == 1) && float_wb_yumi_i) ||
                     ((r == 2) && icache_yumi_i));
        consumed_direct = deq && (mq.size() == 0);
        enq = resp_v_i && (mq.size() < 2) && !consumed_direct;
        if (deq && mq.size() > 0) void'(mq.pop_front());
        if (enq) mq.push_back(inc);
        if (enq || consumed_direct) mpend--;
        if (issue_i) mpend++;
        if (issue_i && !deq && mcnt < 16) mcnt++;
        else if (deq && !issue_i && mcnt > 0) mcnt--;
    endtask

    task automatic drive_idle();
        issue_i          = 1'b0;
        resp_v_i         = 1'b0;
        resp_data_i      = '0;
        resp_load_info_i = '0;
        resp_reg_id_i    = '0;
        int_wb_yumi_i    = 1'b0;
        float_wb_yumi_i  = 1'b0;
        icache_yumi_i    = 1'b0;
    endtask

    // Called at posedge+1; returns at the following posedge+1 with idle inputs.
    task automatic step(input logic iss, input logic rv, input logic [31:0] d,
                        input bsg_manycore_load_info_s li, input logic [4:0] rd,
                        input logic yi, input logic yf, input logic yc);
        issue_i          = iss;
        resp_v_i         = rv;
        resp_data_i      = d;
        resp_load_info_i = li;
        resp_reg_id_i    = rd;
        int_wb_yumi_i    = yi;
        float_wb_yumi_i  = yf;
        icache_yumi_i    = yc;
        #1;
        compare_model();
        model_update();
        @(posedge clk_i);
        #1;
        drive_idle();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"},    32'(resp_ready_o),    32'd1);
        check({tag, "_idle"},     32'(idle_o),          32'd1);
        check({tag, "_int_v"},    32'(int_wb_v_o),      32'd0);
        check({tag, "_float_v"},  32'(float_wb_v_o),    32'd0);
        check({tag, "_icache_v"}, 32'(icache_v_o),      32'd0);
        check({tag, "_count"},    32'(out_count_o),     32'd0);
        check({tag, "_full"},     32'(out_full_o),      32'd0);
        check({tag, "_int_rd"},   32'(int_wb_rd_o),     32'd0);
        check({tag, "_int_data"}, int_wb_data_o,        32'd0);
        check({tag, "_fl_rd"},    32'(float_wb_rd_o),   32'd0);
        check({tag, "_fl_data"},  float_wb_data_o,      32'd0);
        check({tag, "_ic_data"},  icache_data_o,        32'd0);
    endtask

    task automatic model_reset();
        mq.delete();
        mcnt  = 0;
        mpend = 0;
    endtask

    bsg_manycore_load_info_s c_word;

    initial begin
        drive_idle();
        model_reset();
        c_word  = mk_info(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        reset_i = 1'b0;
        #12;
        check_reset_values("rst");
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Fill the outstanding counter
        repeat (16) step(1'b1, 1'b0, '0, c_word, 5'd0, 1'b0, 1'b0, 1'b0);
        check("full16", 32'(out_full_o),  32'd1);
        check("cnt16",  32'(out_count_o), 32'd16);

        // Signed byte, part_sel 3
        step(1'b0, 1'b1, 32'h80FF_1234, mk_info(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3), 5'd5, 1'b0, 1'b0, 1'b0);
        check("sbyte_v",    32'(int_wb_v_o),  32'd1);
        check("sbyte_rd",   32'(int_wb_rd_o), 32'd5);
        check("sbyte_data", int_wb_data_o,    32'hFFFF_FF80);
        step(1'b0, 1'b0, '0, c_word, 5'd0, 1'b1, 1'b0, 1'b0);

        // Unsigned hex, then dequeue together with a new issue
        step(1'b0, 1'b1, 32'hBEEF_0000, mk_info(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2), 5'd7, 1'b0, 1'b0, 1'b0);
        check("uhex_data", int_wb_data_o, 32'h0000_BEEF);
        step(1'b1, 1'b0, '0, c_word, 5'd0, 1'b1, 1'b0, 1'b0);
        check("issue_deq_cnt", 32'(out_count_o), 32'd15);

        // Signed hex
        step(1'b0, 1'b1, 32'hBEEF_0000, mk_info(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2), 5'd7, 1'b0, 1'b0, 1'b0);
        check("shex_data", int_wb_data_o, 32'hFFFF_BEEF);
        step(1'b0, 1'b0, '0, c_word, 5'd0, 1'b1, 1'b0, 1'b0);

        // icache route ignores part_sel / extension
        step(1'b0, 1'b1, 32'h0000_0013, mk_info(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1), 5'd9, 1'b0, 1'b0, 1'b0);
        check("ic_v",    32'(icache_v_o),   32'd1);
        check("ic_intv", 32'(int_wb_v_o),   32'd0);
        check("ic_flv",  32'(float_wb_v_o), 32'd0);
        check("ic_data", icache_data_o,     32'h0000_0013);
        step(1'b0, 1'b0, '0, c_word, 5'd0, 1'b0, 1'b0, 1'b1);

        // float route
        step(1'b0, 1'b1, 32'h3F80_0000, mk_info(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2), 5'd3, 1'b0, 1'b0, 1'b0);
        check("fl_v",    32'(float_wb_v_o),  32'd1);
        check("fl_intv", 32'(int_wb_v_o),    32'd0);
        check("fl_icv",  32'(icache_v_o),    32'd0);
        check("fl_rd",   32'(float_wb_rd_o), 32'd3);
        check("fl_data", float_wb_data_o,    32'h3F80_0000);
        step(1'b0, 1'b0, '0, c_word, 5'd0, 1'b0, 1'b1, 1'b0);
        check("cnt12", 32'(out_count_o), 32'd12);

        // x0 load is dropped silently
        step(1'b0, 1'b1, 32'hDEAD_BEEF, c_word, 5'd0, 1'b0, 1'b0, 1'b0);
        check("x0_intv", 32'(int_wb_v_o), 32'd0);
`ifndef REMOTE_LOAD_WB_BYPASS_EN
        check("x0_cnt_before", 32'(out_count_o), 32'd12);
`endif
        step(1'b0, 1'b0, '0, c_word, 5'd0, 1'b0, 1'b0, 1'b0);
        check("x0_cnt_after", 32'(out_count_o), 32'd11);

        // Backpressure: three back-to-back responses, yumi low
        step(1'b0, 1'b1, 32'h1111_1111, c_word, 5'd1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h2222_2222, c_word, 5'd2, 1'b0, 1'b0, 1'b0);
        check("bp_ready0", 32'(resp_ready_o), 32'd0);
        step(1'b0, 1'b1, 32'h3333_3333, c_word, 5'd3, 1'b0, 1'b0, 1'b0);
        check("bp_head_a", int_wb_data_o, 32'h1111_1111);
        step(1'b0, 1'b1, 32'h3333_3333, c_word, 5'd3, 1'b1, 1'b0, 1'b0);
        check("bp_ready1", 32'(resp_ready_o), 32'd1);
        check("bp_head_b", int_wb_data_o,     32'h2222_2222);
        step(1'b0, 1'b1, 32'h3333_3333, c_word, 5'd3, 1'b1, 1'b0, 1'b0);
        check("bp_head_c", int_wb_data_o, 32'h3333_3333);
        step(1'b0, 1'b0, '0, c_word, 5'd0, 1'b1, 1'b0, 1'b0);
        check("bp_cnt", 32'(out_count_o), 32'd8);

        // Drain the remaining outstanding loads
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 32'(i * 32'h0101_0101), c_word, 5'd9, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, '0, c_word, 5'd0, 1'b1, 1'b0, 1'b0);
        end
        check("drain_idle", 32'(idle_o),      32'd1);
        check("drain_cnt",  32'(out_count_o), 32'd0);

        // Asynchronous reset with the queue full and count 7
        repeat (7) step(1'b1, 1'b0, '0, c_word, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'hAAAA_5555, c_word, 5'd4, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h5555_AAAA, c_word, 5'd6, 1'b0, 1'b0, 1'b0);
        check("pre_rst_ready", 32'(resp_ready_o), 32'd0);
        check("pre_rst_cnt",   32'(out_count_o),  32'd7);
        #2;
        reset_i = 1'b0;
        #1;
        check_reset_values("arst");
        model_reset();
        @(negedge clk_i);
        reset_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Randomized traffic against the reference model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int p_iss, p_rsp, p_yum;
            logic iss, rv, yi, yf, yc;
            remote_load_resp_s e, h;
            bit hv;
            case ((cyc / 500) % 4)
                0:       begin p_iss = 70; p_rsp = 30; p_yum = 80;  end
                1:       begin p_iss = 20; p_rsp = 80; p_yum = 30;  end
                2:       begin p_iss = 50; p_rsp = 50; p_yum = 100; end
                default: begin p_iss = 40; p_rsp = 60; p_yum = 60;  end
            endcase
            iss = (mcnt < 16) && ($urandom_range(99) < 32'(p_iss));
            rv  = (mpend > 0) && ($urandom_range(99) < 32'(p_rsp));
            e.data      = $urandom;
            e.load_info = bsg_manycore_load_info_s'(7'($urandom_range(127)));
            e.reg_id    = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            hv = head_of(rv, e, h);
            yi = 1'b0;
            yf = 1'b0;
            yc = 1'b0;
            if (hv && ($urandom_range(99) < 32'(p_yum))) begin
                case (route_of(h))
                    0:       yi = (h.reg_id != 0);
                    1:       yf = 1'b1;
                    default: yc = 1'b1;
                endcase
            end
            step(iss, rv, e.data, e.load_info, e.reg_id, yi, yf, yc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
